// File: rtl/note_player.sv
// note_player: fetches a note's phase step from the frequency ROM and plays it for N beats.
// Latency: step_size valid 2 cycles after the load strobe; done_with_note is combinational in the completing cycle.
// Backpressure: loads are only accepted in IDLE; play_enable=0 freezes the beat count, state and sample advance.
// Ports: clk/reset (sync, active-low); play_enable, load_new_note, note_to_load, duration_to_load, beat,
//        generate_next_sample in; rom_addr out / rom_data in; step_size, generate_next, done_with_note, busy out.
module note_player #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_to_load,
  input  logic [DUR_W-1:0]  duration_to_load,
  input  logic              beat,
  input  logic              generate_next_sample,
  output logic [NOTE_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic [19:0]       step_size,
  output logic              generate_next,
  output logic              done_with_note,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t            state;
  state_t            next_state;
  logic [DUR_W-1:0]  beat_cnt;
  logic              finish;

  // Completion: a zero count finishes at once, a count of one finishes on its beat.
  // Gated by reset so a reset cycle can never emit a done pulse; gated by
  // play_enable so a paused note stays frozen.
  assign finish = reset && (state == PLAY) && play_enable &&
                  ((beat_cnt == '0) || ((beat_cnt == DUR_W'(1)) && beat));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_new_note) next_state = FETCH;
      FETCH:   next_state = PLAY;
      PLAY:    if (finish) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done_with_note = finish;
    busy           = (state != IDLE);
    generate_next  = reset && generate_next_sample && play_enable && (state == PLAY);
  end

  // Datapath: note address, beat counter and registered step size
  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr  <= '0;
      beat_cnt  <= '0;
      step_size <= '0;
    end else begin
      case (state)
        IDLE: begin
          step_size <= '0;
          if (load_new_note) begin
            rom_addr <= note_to_load;
            beat_cnt <= duration_to_load;
          end
        end
        FETCH: begin
          // A rest must be silent whatever the ROM holds at address 0.
          step_size <= (rom_addr == '0) ? 20'd0 : rom_data;
        end
        PLAY: begin
          if (finish) begin
            step_size <= '0;
            beat_cnt  <= '0;
          end else if (play_enable && beat && (beat_cnt != '0)) begin
            beat_cnt <= beat_cnt - DUR_W'(1);
          end
        end
        default: begin
          step_size <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed stimulus for note_player checked against a beat-level note model.
// Latency: model and DUT compared on every falling edge once reset has been applied.
// Backpressure: none; the bench drives all inputs directly.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        beat;
  logic        generate_next_sample;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data;
  logic [19:0] step_size;
  logic        generate_next;
  logic        done_with_note;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic cmp_on = 1'b0;

  always #5 clk = ~clk;

  note_player #(.NOTE_W(6), .DUR_W(6)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .rom_addr             (rom_addr),
    .rom_data             (rom_data),
    .step_size            (step_size),
    .generate_next        (generate_next),
    .done_with_note       (done_with_note),
    .busy                 (busy)
  );

  // Frequency ROM contents; address 0 deliberately non-zero to prove rests are muted.
  function automatic logic [19:0] rom_f(input logic [5:0] a);
    if (a == 6'd5) return 20'h01A2B;
    return 20'h10000 + {14'd0, a} * 20'd3;
  endfunction

  assign rom_data = rom_f(rom_addr);

  // Note model: a note is "active" from the accepted load until it completes,
  // spends its first cycle fetching, then counts beats down while enabled.
  logic        m_active = 1'b0;
  logic        m_fetched = 1'b0;
  int          m_beats = 0;
  logic [5:0]  m_addr = '0;
  logic [19:0] m_step = '0;

  function automatic logic exp_done();
    return reset && m_active && m_fetched && play_enable &&
           ((m_beats == 0) || ((m_beats == 1) && beat));
  endfunction

  function automatic logic exp_gen();
    return reset && generate_next_sample && play_enable && m_active && m_fetched;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_active  <= 1'b0;
      m_fetched <= 1'b0;
      m_beats   <= 0;
      m_addr    <= '0;
      m_step    <= '0;
    end else if (!m_active) begin
      if (load_new_note) begin
        m_active  <= 1'b1;
        m_fetched <= 1'b0;
        m_addr    <= note_to_load;
        m_beats   <= int'(duration_to_load);
      end
    end else if (!m_fetched) begin
      m_fetched <= 1'b1;
      m_step    <= (m_addr == 6'd0) ? 20'd0 : rom_f(m_addr);
    end else if (exp_done()) begin
      m_active  <= 1'b0;
      m_fetched <= 1'b0;
      m_beats   <= 0;
      m_step    <= '0;
    end else if (play_enable && beat && (m_beats > 0)) begin
      m_beats <= m_beats - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("step_size", {12'd0, step_size}, {12'd0, m_step});
    chk("rom_addr", {26'd0, rom_addr}, {26'd0, m_addr});
    chk("done_with_note", {31'd0, done_with_note}, {31'd0, exp_done()});
    chk("generate_next", {31'd0, generate_next}, {31'd0, exp_gen()});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    load_new_note    = 1'b1;
    note_to_load     = n;
    duration_to_load = d;
    tick();
    load_new_note    = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  initial begin
    reset = 1'b0; play_enable = 1'b1; load_new_note = 1'b0; note_to_load = '0;
    duration_to_load = '0; beat = 1'b0; generate_next_sample = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (cmp_on) compare_all();
      end
    join_none

    tick(); tick();
    cmp_on = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_step", {12'd0, step_size}, 32'd0);
    chk("reset_addr", {26'd0, rom_addr}, 32'd0);
    chk("reset_gen", {31'd0, generate_next}, 32'd0);
    reset = 1'b1;
    tick();

    // Note 5 for 3 beats
    load(6'd5, 6'd3);
    chk("n5_fetch_busy", {31'd0, busy}, 32'd1);
    chk("n5_addr", {26'd0, rom_addr}, 32'd5);
    tick();
    chk("n5_step", {12'd0, step_size}, 32'h01A2B);
    pulse_beat(); tick();
    pulse_beat(); tick();
    beat = 1'b1; #1;
    chk("n5_done_3rd_beat", {31'd0, done_with_note}, 32'd1);
    tick(); beat = 1'b0; #1;
    chk("n5_done_single", {31'd0, done_with_note}, 32'd0);
    chk("n5_step_cleared", {12'd0, step_size}, 32'd0);
    chk("n5_idle", {31'd0, busy}, 32'd0);
    tick();

    // Zero-length note
    load(6'd7, 6'd0);
    chk("d0_no_done_fetch", {31'd0, done_with_note}, 32'd0);
    tick();
    chk("d0_done_2_after", {31'd0, done_with_note}, 32'd1);
    chk("d0_busy_2nd", {31'd0, busy}, 32'd1);
    tick();
    chk("d0_idle", {31'd0, busy}, 32'd0);
    tick();

    // Pause with 2 beats left
    load(6'd2, 6'd4);
    tick();
    pulse_beat(); pulse_beat();
    play_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat = 1'b1; #1;
      chk("pause_gen", {31'd0, generate_next}, 32'd0);
      chk("pause_no_done", {31'd0, done_with_note}, 32'd0);
      tick(); beat = 1'b0; tick();
    end
    chk("pause_step_held", {12'd0, step_size}, 32'h10006);
    chk("pause_busy", {31'd0, busy}, 32'd1);
    play_enable = 1'b1;
    pulse_beat();
    beat = 1'b1; #1;
    chk("resume_done", {31'd0, done_with_note}, 32'd1);
    tick(); beat = 1'b0;
    tick();

    // Load during PLAY is ignored; load at completion is ignored
    load(6'd3, 6'd2);
    tick();
    load(6'd9, 6'd1);
    chk("ign_addr", {26'd0, rom_addr}, 32'd3);
    chk("ign_step", {12'd0, step_size}, 32'h10009);
    pulse_beat();
    beat = 1'b1; load_new_note = 1'b1; note_to_load = 6'd6; #1;
    chk("ign_done", {31'd0, done_with_note}, 32'd1);
    tick(); beat = 1'b0; load_new_note = 1'b0; #1;
    chk("coll_idle", {31'd0, busy}, 32'd0);
    chk("coll_addr", {26'd0, rom_addr}, 32'd3);
    tick();

    // Reset mid-PLAY
    load(6'd4, 6'd5);
    tick();
    pulse_beat();
    reset = 1'b0; beat = 1'b1; #1;
    chk("rst_no_done", {31'd0, done_with_note}, 32'd0);
    chk("rst_gen", {31'd0, generate_next}, 32'd0);
    tick(); reset = 1'b1; beat = 1'b0; #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_step", {12'd0, step_size}, 32'd0);
    chk("rst_addr", {26'd0, rom_addr}, 32'd0);
    tick();

    // Rest note
    load(6'd0, 6'd2);
    tick();
    chk("rest_step", {12'd0, step_size}, 32'd0);
    generate_next_sample = 1'b0; #1;
    chk("rest_gen_lo", {31'd0, generate_next}, 32'd0);
    generate_next_sample = 1'b1; #1;
    chk("rest_gen_hi", {31'd0, generate_next}, 32'd1);
    pulse_beat();
    beat = 1'b1; #1;
    chk("rest_done", {31'd0, done_with_note}, 32'd1);
    tick(); beat = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The block SHALL have parameter NOTE_W, default 6, meaning the note-number width; note 0 is a rest.
REQ-002 The block SHALL have parameter DUR_W, default 6, meaning the duration width in beats.
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port play_enable, input, 1; high means play, low means pause.
REQ-006 The block SHALL have port load_new_note, input, 1, a one-cycle load strobe.
REQ-007 The block SHALL have port note_to_load, input, NOTE_W, the note number.
REQ-008 The block SHALL have port duration_to_load, input, DUR_W, the note length in beats.
REQ-009 The block SHALL have port beat, input, 1, a one-cycle beat tick.
REQ-010 The block SHALL have port generate_next_sample, input, 1, the codec sample request.
REQ-011 The block SHALL have port rom_addr, output, NOTE_W, the frequency-ROM address.
REQ-012 The block SHALL have port rom_data, input, 20, the ROM step size, valid 1 cycle after rom_addr.
REQ-013 The block SHALL have port step_size, output, 20, the registered phase increment to sine_reader.
REQ-014 The block SHALL have port generate_next, output, 1, the sample advance to sine_reader.
REQ-015 The block SHALL have port done_with_note, output, 1, a one-cycle completion pulse.
REQ-016 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH and PLAY.
REQ-018 IDLE, load_new_note=1: the block SHALL latch the note into rom_addr and the duration into the beat counter, then go to FETCH.
REQ-019 IDLE, load_new_note=0: the block SHALL stay in IDLE with step_size=0.
REQ-020 FETCH SHALL last exactly 1 cycle; at its end step_size SHALL be loaded from rom_data (0 if the note is 0, regardless of rom_data) and the FSM SHALL go to PLAY.
REQ-021 In PLAY, beat=1 with play_enable=1 SHALL decrement the beat counter.
REQ-022 When PLAY decrements the counter from 1 to 0, the block SHALL pulse done_with_note high in that same cycle, clear step_size to 0 on the next edge, and go to IDLE.
REQ-023 A duration of 0 SHALL complete in the first PLAY cycle without waiting for a beat, pulsing done_with_note.
REQ-024 play_enable=0 SHALL freeze the beat counter and FSM state and hold generate_next low; step_size SHALL be held.
REQ-025 generate_next SHALL be a combinational function equal to generate_next_sample AND play_enable AND (state==PLAY).
REQ-026 load_new_note asserted in FETCH or PLAY SHALL be ignored, with no state change and no relatch.
REQ-027 On a simultaneous completion and load_new_note in the same cycle, the load SHALL be ignored; a load is accepted only in IDLE.
REQ-028 done_with_note SHALL never be high for more than 1 consecutive cycle.
REQ-029 rom_addr SHALL be registered and hold its value from load until the next accepted load.

Reset
REQ-030 reset=0 at a clock edge SHALL force: state IDLE, step_size=0, beat counter=0, rom_addr=0, done_with_note=0, busy=0.
REQ-031 Reset SHALL take priority over all other inputs, including mid-FETCH and mid-PLAY, and SHALL not produce a done_with_note pulse.
REQ-032 generate_next SHALL be 0 while in reset.

Verification
REQ-033 Bench SHALL cover: load note 5, duration 3, play_enable=1, rom_data=0x01A2B -> step_size=0x01A2B 2 cycles after the load; done_with_note pulses on the 3rd beat; then step_size=0.
REQ-034 Bench SHALL cover: load duration 0 -> done_with_note exactly 2 cycles after the load strobe; busy high for 2 cycles.
REQ-035 Bench SHALL cover: pause with 2 beats remaining, 4 beats applied while paused -> counter unchanged and generate_next=0; resume plus 2 beats -> done.
REQ-036 Bench SHALL cover: load_new_note pulsed during PLAY with note 9 -> rom_addr and step_size unchanged, and the original note completes normally.
REQ-037 Bench SHALL cover: reset=0 mid-PLAY -> next cycle IDLE, step_size=0, busy=0, no done pulse.
REQ-038 Bench SHALL cover: rest note 0, duration 2 -> step_size=0 throughout, generate_next still follows generate_next_sample, done after 2 beats.
